// File: rtl/mnv3_weight_pkg.sv
// mnv3_weight_pkg: shared state/error encodings and defaults for the weight stream unpacker
package mnv3_weight_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_MAGIC, S_BASE, S_LEN, S_PAY, S_EMIT, S_SUM, S_WAIT, S_DONE, S_DRAIN, S_ERR
  } wsu_state_e;
  typedef enum logic [2:0] {
    E_NONE, E_MAGIC, E_LEN, E_TRUNC, E_FRAME, E_CSUM, E_LOADER, E_TIMEOUT
  } wsu_err_e;
  localparam logic [31:0] WSU_MAGIC = 32'h4D4E5633;
  localparam logic [31:0] WSU_MAX_BYTES = 32'h0100_0000;
  localparam int WSU_DONE_TIMEOUT = 1024;
endpackage

// File: rtl/weight_word_serializer.sv
// weight_word_serializer: holds one 32-bit word and emits its low cnt bytes, one per cycle
module weight_word_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic [2:0]  cnt_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  output logic        last_o
);
  logic [31:0] word_q;
  logic [2:0]  cnt_q;
  logic [1:0]  idx_q;
  logic        act_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      act_q  <= 1'b0;
    end else if (clr_i) begin
      act_q <= 1'b0;
    end else if (load_i) begin
      word_q <= word_i;
      cnt_q  <= cnt_i;
      idx_q  <= '0;
      act_q  <= 1'b1;
    end else if (act_q) begin
      idx_q <= idx_q + 2'd1;
      act_q <= !last_o;
    end
  end
  assign byte_o  = word_q[{idx_q, 3'b000} +: 8];
  assign valid_o = act_q;
  assign last_o  = act_q && (({1'b0, idx_q} + 3'd1) == cnt_q);
endmodule

// File: rtl/weight_stream_unpacker.sv
// weight_stream_unpacker: checks a framed 32-bit weight stream and replays its
// payload as byte writes into WeightLoader, then waits for the loader verdict.
module weight_stream_unpacker
  import mnv3_weight_pkg::*;
#(
  parameter int          DATA_WIDTH   = 8,
  parameter int          ADDR_WIDTH   = 32,
  parameter logic [31:0] MAGIC        = WSU_MAGIC,
  parameter logic [31:0] MAX_BYTES    = WSU_MAX_BYTES,
  parameter int          DONE_TIMEOUT = WSU_DONE_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [31:0]           s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] weight_addr,
  output logic [DATA_WIDTH-1:0] weight_data,
  output logic                  weight_write_en,
  output logic                  weight_load_start,
  input  logic                  weight_load_done,
  input  logic                  weight_load_error,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_code,
  output logic [31:0]           bytes_written
);
  wsu_state_e  state_q;
  wsu_err_e    err_q, f_err;
  logic [31:0] base_q, rem_q, sum_q, bw_q, tmr_q, addr_full;
  logic        start_q, done_q, error_q;
  logic        acc, is_start, len_bad, ser_load, ser_valid, ser_last;
  logic [2:0]  ser_cnt;
  logic [7:0]  ser_byte;
  assign s_ready   = state_q inside {S_IDLE, S_MAGIC, S_BASE, S_LEN, S_PAY, S_SUM, S_DRAIN};
  assign acc       = s_valid && s_ready;
  assign is_start  = state_q inside {S_IDLE, S_MAGIC};
  assign len_bad   = (s_data > MAX_BYTES) ||
                     (({32'd0, base_q} + {32'd0, s_data}) > (64'd1 << ADDR_WIDTH));
  // Content errors outrank truncation; a faulty word carrying s_last skips the drain.
  assign f_err = state_q == S_SUM ? (!s_last ? E_FRAME : s_data != sum_q ? E_CSUM : E_NONE)
               : (is_start && s_data != MAGIC) ? E_MAGIC
               : (state_q == S_LEN && len_bad) ? E_LEN
               : s_last ? E_TRUNC : E_NONE;
  assign ser_cnt   = rem_q > 32'd4 ? 3'd4 : rem_q[2:0];
  assign ser_load  = acc && state_q == S_PAY && f_err == E_NONE && !abort;
  weight_word_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (abort),
    .load_i  (ser_load),
    .word_i  (s_data),
    .cnt_i   (ser_cnt),
    .byte_o  (ser_byte),
    .valid_o (ser_valid),
    .last_o  (ser_last)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      rem_q   <= '0;
      sum_q   <= '0;
      bw_q    <= '0;
      tmr_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      err_q   <= E_NONE;
    end else begin
      start_q <= 1'b0;
      if (ser_valid) begin
        bw_q  <= bw_q + 32'd1;
        sum_q <= sum_q + {24'd0, ser_byte};
      end
      if (abort) begin
        state_q <= S_IDLE;
        done_q  <= 1'b0;
        error_q <= 1'b0;
        err_q   <= E_NONE;
      end else if (state_q == S_DRAIN) begin
        if (acc && s_last) begin
          state_q <= S_ERR;
          error_q <= 1'b1;
        end
      end else if (state_q == S_WAIT) begin
        tmr_q <= tmr_q + 32'd1;
        if (weight_load_error || (!weight_load_done && tmr_q == 32'(DONE_TIMEOUT - 1))) begin
          state_q <= S_ERR;
          error_q <= 1'b1;
          err_q   <= weight_load_error ? E_LOADER : E_TIMEOUT;
        end else if (weight_load_done) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
      end else if (state_q == S_EMIT) begin
        if (ser_last) state_q <= rem_q == 32'd0 ? S_SUM : S_PAY;
      end else if (state_q inside {S_DONE, S_ERR}) begin
        state_q <= S_IDLE;
      end else if (acc) begin
        if (is_start) begin
          done_q  <= 1'b0;
          error_q <= 1'b0;
          err_q   <= E_NONE;
          bw_q    <= '0;
          sum_q   <= '0;
        end
        if (f_err != E_NONE) begin
          state_q <= s_last ? S_ERR : S_DRAIN;
          error_q <= s_last;
          err_q   <= f_err;
        end else begin
          case (state_q)
            S_IDLE, S_MAGIC: state_q <= S_BASE;
            S_BASE: begin
              base_q  <= s_data;
              state_q <= S_LEN;
            end
            S_LEN: begin
              rem_q   <= s_data;
              start_q <= 1'b1;
              state_q <= s_data == 32'd0 ? S_SUM : S_PAY;
            end
            S_PAY: begin
              rem_q   <= rem_q - {29'd0, ser_cnt};
              state_q <= S_EMIT;
            end
            S_SUM: begin
              tmr_q   <= '0;
              state_q <= S_WAIT;
            end
            default: ;
          endcase
        end
      end
    end
  end
  assign addr_full         = base_q + bw_q;
  assign weight_addr       = addr_full[ADDR_WIDTH-1:0];
  assign weight_data       = ser_byte;
  assign weight_write_en   = ser_valid;
  assign weight_load_start = start_q;
  assign busy              = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign done              = done_q;
  assign error             = error_q;
  assign err_code          = err_q;
  assign bytes_written     = bw_q;
endmodule

// File: tb/tb_weight_stream_unpacker.sv
// tb_weight_stream_unpacker: directed frames against a byte-write scoreboard
// built from the frame contents, plus hand-computed status expectations.
module tb_weight_stream_unpacker;
  localparam logic [31:0] MAGIC = 32'h4D4E5633;
  typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;
  logic        clk = 0, rst, s_valid, s_last, s_ready, abort;
  logic [31:0] s_data, weight_addr, bytes_written;
  logic [7:0]  weight_data;
  logic        weight_write_en, weight_load_start, weight_load_done, weight_load_error;
  logic        busy, done, error;
  logic [2:0]  err_code;
  int          n_chk = 0, n_fail = 0, starts = 0, starts0;
  wr_t         exp_q[$];
  logic [7:0]  pay[16];
  logic [31:0] last_sum, last_a;
  logic [7:0]  last_d;

  weight_stream_unpacker dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .abort(abort), .weight_addr(weight_addr), .weight_data(weight_data),
    .weight_write_en(weight_write_en), .weight_load_start(weight_load_start),
    .weight_load_done(weight_load_done), .weight_load_error(weight_load_error),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .bytes_written(bytes_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every write the DUT makes must be the next byte the scoreboard expects.
  always @(negedge clk) begin : cmp
    wr_t e;
    if (rst && weight_write_en) begin
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(weight_addr), 64'(e.a));
        chk("wr_data", 64'(weight_data), 64'(e.d));
        last_a = weight_addr;
        last_d = weight_data;
      end
    end
    if (rst && weight_load_start) starts++;
  end

  task automatic send(input logic [31:0] d, input logic l);
    int k = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("send_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] base, input int n, input int trunc_at,
                            input logic [31:0] sum_delta);
    logic [31:0] w, s;
    s = 0;
    send(MAGIC, 0);
    send(base, 0);
    send(32'(n), 0);
    for (int i = 0; i < (n + 3) / 4; i++) begin
      w = 0;
      for (int b = 0; b < 4; b++) if (4 * i + b < n) w[8*b +: 8] = pay[4*i+b];
      if (i == trunc_at) begin
        send(w, 1);
        return;
      end
      for (int b = 0; b < 4 && 4 * i + b < n; b++) begin
        exp_q.push_back('{a: base + 32'(4 * i + b), d: pay[4*i+b]});
        s += 32'(pay[4*i+b]);
      end
      send(w, 0);
    end
    last_sum = s;
    send(s + sum_delta, 1);
  endtask

  task automatic loader_done();
    repeat (3) @(negedge clk);
    weight_load_done = 1;
    @(negedge clk);
    weight_load_done = 0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 0; s_valid = 0; s_data = 0; s_last = 0; abort = 0;
    weight_load_done = 0; weight_load_error = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_error", 64'(error), 0);
    chk("rst_err_code", 64'(err_code), 0);
    chk("rst_wen", 64'(weight_write_en), 0);
    chk("rst_start", 64'(weight_load_start), 0);
    chk("rst_bw", 64'(bytes_written), 0);
    chk("rst_addr", 64'(weight_addr), 0);
    rst = 1;
    @(negedge clk);
    // 1: basic six-byte frame
    for (int i = 0; i < 16; i++) pay[i] = 8'(8'h11 * (i + 1));
    starts0 = starts;
    send_frame(32'h100, 6, -1, 0);
    chk("t1_sum_model", 64'(last_sum), 64'h165);
    repeat (3) @(negedge clk);
    chk("t1_wait_busy", 64'(busy), 1);
    chk("t1_wait_done", 64'(done), 0);
    loader_done();
    chk("t1_done", 64'(done), 1);
    chk("t1_busy", 64'(busy), 0);
    chk("t1_error", 64'(error), 0);
    chk("t1_bw", 64'(bytes_written), 6);
    chk("t1_starts", 64'(starts - starts0), 1);
    chk("t1_last_addr", 64'(last_a), 64'h105);
    chk("t1_last_data", 64'(last_d), 64'h66);
    chk("t1_exp_empty", 64'(exp_q.size()), 0);
    // 2: bad magic drains to s_last
    send(32'hDEADBEEF, 0);
    send(1, 0);
    send(2, 0);
    chk("t2_drain_busy", 64'(busy), 1);
    send(3, 1);
    chk("t2_error", 64'(error), 1);
    chk("t2_err_code", 64'(err_code), 1);
    chk("t2_done_cleared", 64'(done), 0);
    chk("t2_bw", 64'(bytes_written), 0);
    // 3: empty frame
    starts0 = starts;
    send_frame(32'h40, 0, -1, 0);
    loader_done();
    chk("t3_done", 64'(done), 1);
    chk("t3_error", 64'(error), 0);
    chk("t3_err_code", 64'(err_code), 0);
    chk("t3_bw", 64'(bytes_written), 0);
    chk("t3_starts", 64'(starts - starts0), 1);
    // 3b: loader done and error together, error wins
    send_frame(32'h40, 0, -1, 0);
    repeat (2) @(negedge clk);
    weight_load_done = 1; weight_load_error = 1;
    @(negedge clk);
    weight_load_done = 0; weight_load_error = 0;
    @(negedge clk);
    chk("t3b_error", 64'(error), 1);
    chk("t3b_err_code", 64'(err_code), 6);
    chk("t3b_done", 64'(done), 0);
    // 4: checksum off by one, then loader timeout
    for (int i = 0; i < 4; i++) pay[i] = 8'(i + 1);
    send_frame(32'h80, 4, -1, 1);
    repeat (2) @(negedge clk);
    chk("t4_err_code", 64'(err_code), 5);
    chk("t4_error", 64'(error), 1);
    chk("t4_bw", 64'(bytes_written), 4);
    send_frame(32'h80, 4, -1, 0);
    repeat (1000) @(negedge clk);
    chk("t4_pre_to_busy", 64'(busy), 1);
    chk("t4_pre_to_error", 64'(error), 0);
    repeat (30) @(negedge clk);
    chk("t4_to_error", 64'(error), 1);
    chk("t4_to_err_code", 64'(err_code), 7);
    chk("t4_to_busy", 64'(busy), 0);
    // 5: s_last on third payload word of a 12-byte frame
    for (int i = 0; i < 12; i++) pay[i] = 8'(8'hA0 + i);
    send_frame(32'h200, 12, 2, 0);
    repeat (2) @(negedge clk);
    chk("t5_err_code", 64'(err_code), 3);
    chk("t5_error", 64'(error), 1);
    chk("t5_bw", 64'(bytes_written), 8);
    chk("t5_exp_empty", 64'(exp_q.size()), 0);
    // 6: abort while byte 2 of the first word is on the bus
    send(MAGIC, 0);
    send(32'h300, 0);
    send(8, 0);
    for (int b = 0; b < 3; b++) exp_q.push_back('{a: 32'h300 + 32'(b), d: pay[b]});
    send({pay[3], pay[2], pay[1], pay[0]}, 0);
    repeat (2) @(negedge clk);
    chk("t6_byte2_wen", 64'(weight_write_en), 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("t6_abort_wen", 64'(weight_write_en), 0);
    chk("t6_abort_busy", 64'(busy), 0);
    chk("t6_abort_error", 64'(error), 0);
    chk("t6_bw", 64'(bytes_written), 3);
    repeat (3) @(negedge clk);
    chk("t6_exp_empty", 64'(exp_q.size()), 0);
    // 6b: frame ending exactly at the top of the address space
    for (int i = 0; i < 4; i++) pay[i] = 8'(8'hF1 + i);
    send_frame(32'hFFFF_FFFC, 4, -1, 0);
    loader_done();
    chk("t6b_done", 64'(done), 1);
    chk("t6b_bw", 64'(bytes_written), 4);
    chk("t6b_last_addr", 64'(last_a), 64'hFFFF_FFFF);
    // 7: length errors and the largest legal length
    send(MAGIC, 0);
    send(32'hFFFF_FFFD, 0);
    send(4, 0);
    chk("t7_drain_busy", 64'(busy), 1);
    send(0, 1);
    chk("t7_addr_err_code", 64'(err_code), 2);
    send(MAGIC, 0);
    send(0, 0);
    send(32'h0100_0001, 0);
    send(0, 1);
    chk("t7_len_err_code", 64'(err_code), 2);
    chk("t7_len_error", 64'(error), 1);
    starts0 = starts;
    send(MAGIC, 0);
    send(0, 0);
    send(32'h0100_0000, 0);
    @(negedge clk);
    chk("t7_max_busy", 64'(busy), 1);
    chk("t7_max_error", 64'(error), 0);
    chk("t7_max_starts", 64'(starts - starts0), 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("t7_abort_busy", 64'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
